// File: rtl/cc_fstall_skid.sv
// Skid FIFO behind the frontend stall-capture register: registered output stage,
// DEPTH-entry circular buffer and early fstall. Optional sticky overflow flag: CC_FSTALL_SKID_OVF_EN.
module cc_fstall_skid #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       except,
    input  logic                       in_en,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       out_stall,
    output logic                       out_en,
    output logic [WIDTH-1:0]           out_data,
    output logic                       fstall,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             out_en_reg, out_en_next;
    logic [WIDTH-1:0] out_data_reg;
    logic             fstall_reg, fstall_next;

    logic [AW-1:0] wr_idx, rd_idx;
    logic          empty, full;
    logic          pop, bypass, push;

    assign wr_idx = wr_ptr_reg[AW-1:0];
    assign rd_idx = rd_ptr_reg[AW-1:0];
    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

    // A pop frees the head slot in the same cycle, so a push alongside it always fits.
    assign pop    = !out_stall && !empty;
    assign bypass = !out_stall && empty && in_en;
    assign push   = in_en && (out_stall ? !full : !empty);

    always_comb begin
        wr_ptr_next = wr_ptr_reg + PW'(push);
        rd_ptr_next = rd_ptr_reg + PW'(pop);
        count_next  = count_reg + CW'(push) - CW'(pop);
        out_en_next = out_stall ? out_en_reg : (pop || bypass);
        fstall_next = (count_next >= CW'(DEPTH - 2));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            out_en_reg <= 1'b0;
            fstall_reg <= 1'b0;
        end else if (except) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            out_en_reg <= 1'b0;
            fstall_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            out_en_reg <= out_en_next;
            fstall_reg <= fstall_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !except && push) begin
            mem[wr_idx] <= in_data;
        end
    end

    // Output register doubles as the registered read port of the buffer; flush keeps its data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data_reg <= '0;
        end else if (!except) begin
            if (pop) begin
                out_data_reg <= mem[rd_idx];
            end else if (bypass) begin
                out_data_reg <= in_data;
            end
        end
    end

`ifdef CC_FSTALL_SKID_OVF_EN
    logic ovf_reg;
    logic overflow;

    assign overflow = out_stall && in_en && full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_reg <= 1'b0;
        end else if (except) begin
            ovf_reg <= 1'b0;
        end else if (overflow) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ovf = ovf_reg;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && !except) begin
            assert (!overflow) else $error("cc_fstall_skid: word dropped on full buffer");
        end
    end
`endif
`else
    assign ovf = 1'b0;
`endif

    assign out_en   = out_en_reg;
    assign out_data = out_data_reg;
    assign fstall   = fstall_reg;
    assign count    = count_reg;

endmodule

// File: tb/tb_cc_fstall_skid.sv
// Bench for cc_fstall_skid: directed test-plan sequence followed by random traffic,
// all checked every cycle against a queue-based reference model.
module tb_cc_fstall_skid;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
`ifdef CC_FSTALL_SKID_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             except;
    logic             in_en;
    logic [WIDTH-1:0] in_data;
    logic             out_stall;
    logic             out_en;
    logic [WIDTH-1:0] out_data;
    logic             fstall;
    logic [CW-1:0]    count;
    logic             ovf;

    cc_fstall_skid #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .except    (except),
        .in_en     (in_en),
        .in_data   (in_data),
        .out_stall (out_stall),
        .out_en    (out_en),
        .out_data  (out_data),
        .fstall    (fstall),
        .count     (count),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: the FIFO contents as a plain queue plus the visible output state.
    logic [WIDTH-1:0] q[$];
    logic             m_en;
    logic [WIDTH-1:0] m_data;
    logic             m_fstall;
    logic             m_ovf;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic ex, input logic en,
                              input logic [WIDTH-1:0] d, input logic st);
        if (!r) begin
            q.delete();
            m_en = 1'b0; m_data = '0; m_ovf = 1'b0;
        end else if (ex) begin
            q.delete();
            m_en = 1'b0; m_ovf = 1'b0;
        end else if (!st) begin
            if (q.size() > 0) begin
                m_data = q.pop_front();
                m_en   = 1'b1;
                if (en) q.push_back(d);
            end else if (en) begin
                m_data = d;
                m_en   = 1'b1;
            end else begin
                m_en = 1'b0;
            end
        end else if (en) begin
            if (q.size() < DEPTH) q.push_back(d);
            else if (OVF_EN) m_ovf = 1'b1;
        end
        m_fstall = (q.size() >= DEPTH - 2);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
    task automatic cycle(input logic r, input logic ex, input logic en,
                         input logic [WIDTH-1:0] d, input logic st);
        rst = r; except = ex; in_en = en; in_data = d; out_stall = st;
        @(posedge clk);
        model_step(r, ex, en, d, st);
        #1;
        cyc++;
        check("out_en",   WIDTH'(out_en),   WIDTH'(m_en));
        check("out_data", out_data,         m_data);
        check("count",    WIDTH'(count),    WIDTH'(q.size()));
        check("fstall",   WIDTH'(fstall),   WIDTH'(m_fstall));
        check("ovf",      WIDTH'(ovf),      WIDTH'(m_ovf));
        $display("cyc=%0d rst=%0b ex=%0b in_en=%0b in=%h st=%0b | out_en=%0b out=%h cnt=%0d fstall=%0b ovf=%0b",
                 cyc, r, ex, en, d, st, out_en, out_data, count, fstall, ovf);
    endtask

    initial begin
        m_en = 1'b0; m_data = '0; m_fstall = 1'b0; m_ovf = 1'b0;
        rst = 1'b0; except = 1'b0; in_en = 1'b0; in_data = '0; out_stall = 1'b0;

        // Reset with input activity present.
        repeat (2) cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // Bypass.
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0011, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0022, 1'b0);

        // Stall fill with out_en held high.
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_00A1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_00A2, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_00A3, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_00A4, 1'b1);

        // Overflow attempt while full.
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_00C0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1);

        // Drain across the pointer wrap, pushing B1 on release.
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_00B1, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0);

        // Flush mid-operation with three stored words.
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_00D1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_00D2, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_00D3, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_00E1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_00E2, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r, ex, en, st;
            r  = ($urandom_range(0, 199) != 0);
            ex = ($urandom_range(0, 99) < 2);
            en = ($urandom_range(0, 99) < 70);
            st = ($urandom_range(0, 99) < 45);
            cycle(r, ex, en, $urandom(), st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
